delay_line_ctrl: RTL and testbench

- Controller and address sequencer for a RAM-based circular feedback delay line, W x L.
- Generates write/read addresses, clears memory after reset or reconfiguration, and enforces a valid/ready handshake on the sample stream.
- Replaces the full-array shift register with a single write and a single read per sample.
- Sits between the upstream sample source and an external simple dual-port RAM. It feeds the feedback path of comb/IIR stages.

---
 rtl/delay_line_ctrl.sv | 127 ++++++++++++
 tb/tb_delay_line_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_ctrl.sv
// Address sequencer and controller for a RAM-based circular delay line.
// Clears the RAM after reset or reconfiguration, then writes one sample and
// reads the sample written D accepts earlier on every accepted input.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   ena                 global enable; low stalls state and pointers
//   cfg_delay/cfg_load  requested delay and its load strobe (starts a flush)
//   cfg_busy            high while the RAM is being cleared
//   din/valid_in/ready_in   input sample handshake
//   dout/valid_out      delayed sample, one-cycle pulse per accepted input
//   drop_err            sticky: a sample was offered while not ready
//   ram_*               simple dual-port RAM, read-first, 1-cycle read latency
module delay_line_ctrl #(
  parameter  int unsigned W = 12,
  parameter  int unsigned L = 256,
  localparam int unsigned B = $clog2(L)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic [B:0]          cfg_delay,
  input  logic                cfg_load,
  output logic                cfg_busy,
  input  logic signed [W-1:0] din,
  input  logic                valid_in,
  output logic                ready_in,
  output logic signed [W-1:0] dout,
  output logic                valid_out,
  output logic                drop_err,
  output logic                ram_we,
  output logic [B-1:0]        ram_waddr,
  output logic signed [W-1:0] ram_wdata,
  output logic                ram_re,
  output logic [B-1:0]        ram_raddr,
  input  logic signed [W-1:0] ram_rdata
);

  localparam logic [B:0]   DMAX       = (B+1)'(L);
  localparam logic [B-1:0] FLUSH_LAST = B'(L - 1);

  typedef enum logic {
    S_FLUSH = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t       state;
  logic [B-1:0] flush_cnt;
  logic [B-1:0] wp;
  logic [B:0]   dly;
  logic [B:0]   dly_clamped;
  logic         rd_pend;
  logic         accept;
  logic         flush_wr;

  // Requested delay limited to 1..L.
  always_comb begin
    dly_clamped = cfg_delay;
    if (cfg_delay == '0) begin
      dly_clamped = (B+1)'(1);
    end else if (cfg_delay > DMAX) begin
      dly_clamped = DMAX;
    end
  end

  // Handshake and RAM port decode. A cfg_load cycle makes no RAM access and
  // refuses the sample; reset forces every strobe low at once.
  always_comb begin
    ready_in  = reset && ena && (state == S_RUN) && !cfg_load;
    accept    = valid_in && ready_in;
    flush_wr  = reset && ena && (state == S_FLUSH) && !cfg_load;
    ram_we    = flush_wr || accept;
    ram_re    = accept;
    ram_waddr = (state == S_RUN) ? wp : flush_cnt;
    ram_wdata = accept ? din : '0;
    // wp - D mod L; D = L reads the slot being overwritten (read-first).
    ram_raddr = wp - dly[B-1:0];
  end

  // Control state, pointers and sticky drop flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FLUSH;
      cfg_busy  <= 1'b1;
      flush_cnt <= '0;
      wp        <= '0;
      dly       <= DMAX;
      drop_err  <= 1'b0;
    end else begin
      if (cfg_load) begin
        state     <= S_FLUSH;
        cfg_busy  <= 1'b1;
        flush_cnt <= '0;
        dly       <= dly_clamped;
      end else if (ena) begin
        if (state == S_FLUSH) begin
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == FLUSH_LAST) begin
            state    <= S_RUN;
            cfg_busy <= 1'b0;
            wp       <= '0;
          end
        end else if (accept) begin
          wp <= wp + 1'b1;
        end
      end
      // A sample refused by a cfg_load still counts, so set beats clear.
      drop_err <= (drop_err && !cfg_load) || (ena && valid_in && !ready_in);
    end
  end

  // Read return pipeline; runs regardless of ena so issued reads complete.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend   <= 1'b0;
      valid_out <= 1'b0;
      dout      <= '0;
    end else begin
      rd_pend   <= accept;
      valid_out <= rd_pend;
      if (rd_pend) begin
        dout <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Self-checking bench for delay_line_ctrl with L=8, W=12. Includes a
// read-first RAM model and a reference delay model fed from accepted samples.
module tb_delay_line_ctrl;

  localparam int unsigned W = 12;
  localparam int unsigned L = 8;
  localparam int unsigned B = 3;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                ena = 1'b0;
  logic [B:0]          cfg_delay = '0;
  logic                cfg_load = 1'b0;
  logic                cfg_busy;
  logic signed [W-1:0] din = '0;
  logic                valid_in = 1'b0;
  logic                ready_in;
  logic signed [W-1:0] dout;
  logic                valid_out;
  logic                drop_err;
  logic                ram_we;
  logic [B-1:0]        ram_waddr;
  logic signed [W-1:0] ram_wdata;
  logic                ram_re;
  logic [B-1:0]        ram_raddr;
  logic signed [W-1:0] ram_rdata = '0;

  delay_line_ctrl #(.W(W), .L(L)) dut (
    .clk(clk), .reset(reset), .ena(ena),
    .cfg_delay(cfg_delay), .cfg_load(cfg_load), .cfg_busy(cfg_busy),
    .din(din), .valid_in(valid_in), .ready_in(ready_in),
    .dout(dout), .valid_out(valid_out), .drop_err(drop_err),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Read-first RAM: the read samples memory before this edge's write lands.
  logic signed [W-1:0] mem [L];
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem[ram_raddr];
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: delay by D accepted samples, zeros before that.
  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t sb[$];
  int   hist[$];
  int   n_acc = 0;
  int   model_d = 8;

  task automatic model_reset(input int d);
    hist.delete();
    n_acc   = 0;
    model_d = d;
  endtask

  // Monitor: scores valid_out against the queue, pushes on every accept.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (valid_out) begin
        if (sb.size() == 0) begin
          chk("spurious valid_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("dout", int'(dout), e.val);
          chk("valid_out latency", cyc, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        void'(sb.pop_front());
        chk("missing valid_out", 0, 1);
      end
      if (valid_in && ready_in) begin
        chk("accept ram_we", int'(ram_we), 1);
        chk("accept ram_re", int'(ram_re), 1);
        chk("accept ram_waddr", int'(ram_waddr), n_acc % L);
        chk("accept ram_wdata", int'(ram_wdata), int'(din));
        chk("accept ram_raddr", int'(ram_raddr), (n_acc + L - model_d) % L);
        e.val = (n_acc < model_d) ? 0 : hist[n_acc - model_d];
        e.due = cyc + 2;
        sb.push_back(e);
        hist.push_back(int'(din));
        n_acc++;
      end else if (!cfg_busy) begin
        chk("idle ram access", int'({ram_we, ram_re}), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_chk(input string t);
    @(negedge clk);
    chk({t, " valid_out"}, int'(valid_out), 0);
    chk({t, " dout"}, int'(dout), 0);
    chk({t, " drop_err"}, int'(drop_err), 0);
    chk({t, " ram_we"}, int'(ram_we), 0);
    chk({t, " ram_re"}, int'(ram_re), 0);
    chk({t, " ram_waddr"}, int'(ram_waddr), 0);
    chk({t, " ram_raddr"}, int'(ram_raddr), 0);
    chk({t, " ram_wdata"}, int'(ram_wdata), 0);
    chk({t, " ready_in"}, int'(ready_in), 0);
    chk({t, " cfg_busy"}, int'(cfg_busy), 1);
    tick();
  endtask

  // Expects L enabled flush cycles starting now, then RUN with ready_in=1.
  task automatic flush_check(input string t);
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      chk({t, " flush cfg_busy"}, int'(cfg_busy), 1);
      chk({t, " flush ram_we"}, int'(ram_we), 1);
      chk({t, " flush ram_waddr"}, int'(ram_waddr), k);
      chk({t, " flush ram_wdata"}, int'(ram_wdata), 0);
      chk({t, " flush ram_re"}, int'(ram_re), 0);
      chk({t, " flush ready_in"}, int'(ready_in), 0);
      tick();
    end
    @(negedge clk);
    chk({t, " post-flush cfg_busy"}, int'(cfg_busy), 0);
    chk({t, " post-flush ready_in"}, int'(ready_in), 1);
    tick();
  endtask

  task automatic do_cfg(input int cfg, input int exp_d, input string t);
    cfg_delay = (B+1)'(cfg);
    cfg_load  = 1'b1;
    tick();
    cfg_load = 1'b0;
    model_reset(exp_d);
    flush_check(t);
  endtask

  task automatic stream(input int n, input int gap, input int base, input string t);
    for (int k = 0; k < n; k++) begin
      din      = W'(base + k);
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      din      = '0;
      repeat (gap) tick();
    end
    repeat (4) tick();
    chk({t, " drained"}, sb.size(), 0);
  endtask

  typedef struct {
    int cfg;
    int n;
    int gap;
    int exp_d;
  } vec_t;

  initial begin
    vec_t vecs[5];
    vecs[0] = '{3, 10, 0, 3};
    vecs[1] = '{8, 12, 0, 8};
    vecs[2] = '{0, 12, 0, 1};
    vecs[3] = '{15, 10, 1, 8};
    vecs[4] = '{2, 6, 2, 2};

    for (int i = 0; i < L; i++) mem[i] = W'(12'h5A0 + i);

    // Reset state, then the power-up flush.
    ena = 1'b1;
    model_reset(8);
    rst_chk("reset");
    rst_chk("reset hold");
    reset = 1'b1;
    flush_check("power-up");
    stream(10, 0, 1, "power-up D=8");

    // Table-driven delay / clamp sweep.
    for (int i = 0; i < 5; i++) begin
      do_cfg(vecs[i].cfg, vecs[i].exp_d, $sformatf("vec%0d", i));
      stream(vecs[i].n, vecs[i].gap, 1, $sformatf("vec%0d", i));
    end

    // Gaps plus a 3-cycle stall mid-stream; outputs 0,0,5.
    do_cfg(2, 2, "stall");
    din = W'(5); valid_in = 1'b1; tick();
    valid_in = 1'b0; tick();
    ena = 1'b0; valid_in = 1'b1; din = W'(6);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall ready_in", int'(ready_in), 0);
      chk("stall ram_we", int'(ram_we), 0);
      chk("stall ram_re", int'(ram_re), 0);
      tick();
    end
    ena = 1'b1; tick();
    din = W'(7); tick();
    valid_in = 1'b0;
    repeat (4) tick();
    chk("stall drained", sb.size(), 0);
    chk("stall outputs", n_acc, 3);
    chk("stall drop_err", int'(drop_err), 0);

    // Samples offered during a flush are dropped; cfg_load clears and restarts.
    cfg_delay = 4'd5; cfg_load = 1'b1; tick();
    cfg_load = 1'b0; valid_in = 1'b1; din = W'(9);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush-drop ready_in", int'(ready_in), 0);
      tick();
    end
    valid_in = 1'b0;
    @(negedge clk);
    chk("flush-drop drop_err", int'(drop_err), 1);
    chk("flush-drop count", int'(ram_waddr), 3);
    tick();
    cfg_delay = 4'd4; cfg_load = 1'b1; tick();
    cfg_load = 1'b0;
    chk("reload drop_err cleared", int'(drop_err), 0);
    model_reset(4);
    flush_check("restart");
    stream(6, 0, 20, "D=4");

    // cfg_load with a valid sample in RUN: refused and counted as a drop.
    valid_in = 1'b1; din = W'(99); cfg_delay = 4'd3; cfg_load = 1'b1;
    @(negedge clk);
    chk("load+valid ready_in", int'(ready_in), 0);
    tick();
    valid_in = 1'b0; cfg_load = 1'b0;
    chk("load+valid drop_err", int'(drop_err), 1);
    model_reset(3);
    flush_check("load+valid");
    stream(4, 1, 40, "load+valid D=3");

    // Reset at flush count 5.
    cfg_delay = 4'd6; cfg_load = 1'b1; tick();
    cfg_load = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    model_reset(8);
    rst_chk("flush reset");
    rst_chk("flush reset hold");
    reset = 1'b1;
    flush_check("after flush reset");
    stream(10, 0, 100, "after flush reset D=8");

    // Reset with a valid_out pending: the pulse must never appear.
    do_cfg(1, 1, "D=1");
    stream(3, 0, 60, "D=1");
    din = W'(70); valid_in = 1'b1; tick();
    valid_in = 1'b0;
    reset = 1'b0;
    sb.delete();
    model_reset(8);
    rst_chk("stream reset");
    rst_chk("stream reset hold");
    reset = 1'b1;
    flush_check("after stream reset");
    stream(3, 0, 80, "after stream reset D=8");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation reached cycle %0d, expected to finish earlier", cyc);
    $fatal(1);
  end

endmodule
